// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (port 0) and data (port 1).
// Define MEM_PORT_ARB_RR_EN for round-robin idle arbitration.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  m0_req,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic                  m0_we,
   input  logic [3:0]            m0_be,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   input  logic                  m0_lock,
   output logic                  m0_gnt,
   output logic                  m0_rvalid,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   input  logic                  m1_req,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic                  m1_we,
   input  logic [3:0]            m1_be,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   input  logic                  m1_lock,
   output logic                  m1_gnt,
   output logic                  m1_rvalid,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [3:0]            mem_be,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  err
);

   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [PW-1:0] LAST = PW'(MAX_OUTSTANDING - 1);
   localparam logic [CW-1:0] FULL = CW'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

   state_t                     state, state_nxt;
   logic [MAX_OUTSTANDING-1:0] id_mem;
   logic [PW-1:0]              wr_ptr, rd_ptr;
   logic [CW-1:0]              count;
   logic                       sel, sel_req, sel_lock;
   logic                       accept, pop, head;

`ifdef MEM_PORT_ARB_RR_EN
   logic rr_ptr, rr_nxt;
`endif

   always_comb begin
      sel = 1'b0;
      unique case (state)
         LOCK0: sel = 1'b0;
         LOCK1: sel = 1'b1;
         default: begin
`ifdef MEM_PORT_ARB_RR_EN
            if (m0_req && m1_req) sel = rr_ptr;
            else                  sel = m1_req;
`else
            sel = m1_req;
`endif
         end
      endcase
   end

   assign sel_req   = sel ? m1_req   : m0_req;
   assign sel_lock  = sel ? m1_lock  : m0_lock;
   assign mem_addr  = sel ? m1_addr  : m0_addr;
   assign mem_we    = sel ? m1_we    : m0_we;
   assign mem_be    = sel ? m1_be    : m0_be;
   assign mem_wdata = sel ? m1_wdata : m0_wdata;

   // Full blocks issue on the registered count, so a same-cycle pop
   // only frees a slot from the next cycle on.
   assign mem_req = sel_req && (count < FULL);
   assign accept  = mem_req && mem_gnt;
   assign m0_gnt  = accept && !sel;
   assign m1_gnt  = accept && sel;

   assign pop       = mem_rvalid && (count != '0);
   assign head      = id_mem[rd_ptr];
   assign m0_rvalid = pop && !head;
   assign m1_rvalid = pop && head;
   assign m0_rdata  = mem_rdata;
   assign m1_rdata  = mem_rdata;

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:
            if (accept && sel_lock) state_nxt = sel ? LOCK1 : LOCK0;
         LOCK0, LOCK1:
            if (accept && !sel_lock) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

`ifdef MEM_PORT_ARB_RR_EN
   always_comb begin
      rr_nxt = rr_ptr;
      if (accept) rr_nxt = (state == IDLE) ? ~rr_ptr : ~sel;
   end

   always_ff @(posedge clk) begin
      if (reset) rr_ptr <= 1'b0;
      else       rr_ptr <= rr_nxt;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         id_mem <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         err    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            id_mem[wr_ptr] <= sel;
            wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
         if (accept && !pop)
            count <= count + 1'b1;
         else if (pop && !accept)
            count <= count - 1'b1;
         if (mem_rvalid && (count == '0))
            err <= 1'b1;
      end
   end

endmodule
